// File: rtl/glitcher_top.sv
// Glitch controller: the host UART feeds a command parser. The parser either
// forwards bytes to the target UART through a 16-byte FIFO, or configures and
// starts a reset/delay/pulse glitch sequencer.
module glitcher_top #(
  parameter int CLKS_PER_BIT = 104,
  parameter int RST_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ftdi_rx,
  output logic target_tx,
  output logic target_rst,
  output logic glitch_out,
  output logic busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]    RST_LAST  = 32'(RST_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_CMD, P_ARG, P_PASS} p_state_t;
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_DELAY, S_PULSE_HI, S_PULSE_LO} s_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- receiver
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  // Synchronizer and edge history reset low: a line held low across reset
  // must first be seen high before a falling edge can start a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= ftdi_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver: start on falling edge, sample mid-bit LSB first, drop bad stop.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_valid_d = rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ------------------------------------------------------------------ parser
  p_state_t        p_state_q, p_state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [2:0]      arg_sel_q, arg_sel_d;
  logic [7:0]      width_q, width_d;
  logic [7:0]      pcount_q, pcount_d;
  logic [31:0]     delay_q, delay_d;
  logic            fifo_we, start_seq, abort_seq;
  logic            busy_q, busy_d;

  // Parser: pass-through framing, command decode and config register writes.
  always_comb begin
    p_state_d   = p_state_q;
    remaining_d = remaining_q;
    arg_sel_d   = arg_sel_q;
    width_d     = width_q;
    pcount_d    = pcount_q;
    delay_d     = delay_q;
    fifo_we     = 1'b0;
    start_seq   = 1'b0;
    abort_seq   = 1'b0;
    if (rx_valid_q) begin
      case (p_state_q)
        P_IDLE: begin
          if (rx_shift_q == 8'h00) begin
            p_state_d = P_CMD;
          end else begin
            p_state_d   = P_PASS;
            remaining_d = rx_shift_q;
          end
        end
        P_PASS: begin
          fifo_we     = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) p_state_d = P_IDLE;
        end
        P_CMD: begin
          p_state_d = P_IDLE;
          case (rx_shift_q)
            8'hFF: begin
              width_d   = 8'd0;
              pcount_d  = 8'd0;
              delay_d   = 32'd0;
              abort_seq = 1'b1;
            end
            8'h10: begin
              arg_sel_d = 3'd4;
              p_state_d = P_ARG;
            end
            8'h11: begin
              arg_sel_d = 3'd5;
              p_state_d = P_ARG;
            end
            8'h20, 8'h21, 8'h22, 8'h23: begin
              arg_sel_d = {1'b0, rx_shift_q[1:0]};
              p_state_d = P_ARG;
            end
            8'hFE: start_seq = !busy_q;
            default: ;
          endcase
        end
        default: begin
          p_state_d = P_IDLE;
          case (arg_sel_q)
            3'd0:    delay_d[7:0]   = rx_shift_q;
            3'd1:    delay_d[15:8]  = rx_shift_q;
            3'd2:    delay_d[23:16] = rx_shift_q;
            3'd3:    delay_d[31:24] = rx_shift_q;
            3'd4:    width_d        = rx_shift_q;
            default: pcount_d       = rx_shift_q;
          endcase
        end
      endcase
    end
  end

  // Parser state and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q   <= P_IDLE;
      remaining_q <= 8'd0;
      arg_sel_q   <= 3'd0;
      width_q     <= 8'd0;
      pcount_q    <= 8'd0;
      delay_q     <= 32'd0;
    end else begin
      p_state_q   <= p_state_d;
      remaining_q <= remaining_d;
      arg_sel_q   <= arg_sel_d;
      width_q     <= width_d;
      pcount_q    <= pcount_d;
      delay_q     <= delay_d;
    end
  end

  // --------------------------------------------------------------- sequencer
  s_state_t        seq_q, seq_d;
  logic [31:0]     seq_cnt_q, seq_cnt_d;
  logic [7:0]      lw_q, lw_d;
  logic [7:0]      lp_q, lp_d;
  logic [31:0]     ld_q, ld_d;
  logic            trst_q, trst_d;
  logic            gl_q, gl_d;

  // Sequencer: config is latched at start so later writes only affect the next run.
  always_comb begin
    seq_d     = seq_q;
    seq_cnt_d = seq_cnt_q;
    lw_d      = lw_q;
    lp_d      = lp_q;
    ld_d      = ld_q;
    trst_d    = trst_q;
    gl_d      = gl_q;
    busy_d    = busy_q;
    if (abort_seq) begin
      seq_d     = S_IDLE;
      seq_cnt_d = 32'd0;
      trst_d    = 1'b0;
      gl_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (seq_q)
        S_IDLE: begin
          if (start_seq) begin
            seq_d     = S_RESET;
            seq_cnt_d = RST_LAST;
            trst_d    = 1'b1;
            busy_d    = 1'b1;
            lw_d      = (width_q == 8'd0) ? 8'd1 : width_q;
            lp_d      = pcount_q;
            ld_d      = delay_q;
          end
        end
        S_RESET: begin
          if (seq_cnt_q == 32'd0) begin
            trst_d = 1'b0;
            if (ld_q == 32'd0) begin
              seq_d     = S_PULSE_HI;
              seq_cnt_d = 32'(lw_q) - 32'd1;
              gl_d      = 1'b1;
            end else begin
              seq_d     = S_DELAY;
              seq_cnt_d = ld_q - 32'd1;
            end
          end else begin
            seq_cnt_d = seq_cnt_q - 32'd1;
          end
        end
        S_DELAY: begin
          if (seq_cnt_q == 32'd0) begin
            seq_d     = S_PULSE_HI;
            seq_cnt_d = 32'(lw_q) - 32'd1;
            gl_d      = 1'b1;
          end else begin
            seq_cnt_d = seq_cnt_q - 32'd1;
          end
        end
        S_PULSE_HI: begin
          if (seq_cnt_q == 32'd0) begin
            gl_d = 1'b0;
            if (lp_q == 8'd0) begin
              seq_d  = S_IDLE;
              busy_d = 1'b0;
            end else begin
              seq_d     = S_PULSE_LO;
              seq_cnt_d = 32'(lw_q) - 32'd1;
              lp_d      = lp_q - 8'd1;
            end
          end else begin
            seq_cnt_d = seq_cnt_q - 32'd1;
          end
        end
        default: begin
          if (seq_cnt_q == 32'd0) begin
            seq_d     = S_PULSE_HI;
            seq_cnt_d = 32'(lw_q) - 32'd1;
            gl_d      = 1'b1;
          end else begin
            seq_cnt_d = seq_cnt_q - 32'd1;
          end
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q     <= S_IDLE;
      seq_cnt_q <= 32'd0;
      lw_q      <= 8'd1;
      lp_q      <= 8'd0;
      ld_q      <= 32'd0;
      trst_q    <= 1'b0;
      gl_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      seq_cnt_q <= seq_cnt_d;
      lw_q      <= lw_d;
      lp_q      <= lp_d;
      ld_q      <= ld_d;
      trst_q    <= trst_d;
      gl_q      <= gl_d;
      busy_q    <= busy_d;
    end
  end

  // ----------------------------------------------------------------- tx fifo
  logic [7:0]      fifo_mem_q [16];
  logic [3:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      fifo_cnt_q, fifo_cnt_d;
  logic            fifo_push, fifo_pop, fifo_empty;
  logic [7:0]      fifo_rd;

  assign fifo_empty = (fifo_cnt_q == 5'd0);
  assign fifo_rd    = fifo_mem_q[rd_ptr_q];

  // FIFO bookkeeping; writes arriving while full are dropped.
  always_comb begin
    fifo_push  = fifo_we && (fifo_cnt_q != 5'd16);
    wr_ptr_d   = wr_ptr_q + {3'd0, fifo_push};
    rd_ptr_d   = rd_ptr_q + {3'd0, fifo_pop};
    fifo_cnt_d = fifo_cnt_q + {4'd0, fifo_push} - {4'd0, fifo_pop};
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 4'd0;
      rd_ptr_q   <= 4'd0;
      fifo_cnt_q <= 5'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ------------------------------------------------------------- transmitter
  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  // Transmitter: chains directly from stop bit into the next start bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_rd;
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LAST;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: begin
        if (tx_cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rd;
            tx_state_d = TX_START;
            tx_cnt_d   = BIT_LAST;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
    endcase
  end

  // Transmitter state registers; line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign target_tx  = tx_q;
  assign target_rst = trst_q;
  assign glitch_out = gl_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_glitcher_top.sv
// Directed bench for glitcher_top: expected target UART bytes and glitch
// timing events are queued as commands are sent, then matched against
// what the monitors capture.
module tb_glitcher_top;

  localparam int CPB  = 16;
  localparam int RSTC = 16;
  localparam int TMO  = 6000;

  logic clk = 1'b0;
  logic rst;
  logic ftdi_rx = 1'b1;
  logic target_tx, target_rst, glitch_out, busy;

  glitcher_top #(.CLKS_PER_BIT(CPB), .RST_CYCLES(RSTC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ftdi_rx    (ftdi_rx),
    .target_tx  (target_tx),
    .target_rst (target_rst),
    .glitch_out (glitch_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Event kinds: "R" reset high length, "L" low gap before a glitch rise,
  // "H" glitch high length.
  typedef struct packed {
    logic [7:0]  kind;
    logic [31:0] len;
  } ev_t;

  ev_t        got_ev[$];
  ev_t        exp_ev[$];
  logic [7:0] got_tx[$];
  logic [7:0] exp_tx[$];

  int errors = 0;
  int checks = 0;
  int tx_stop_bad = 0;

  int   mon_n = 0;
  int   rise_r = 0;
  int   rise_g = 0;
  int   last_fall = 0;
  logic prev_r = 1'b0;
  logic prev_g = 1'b0;
  logic [7:0] tx_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [7:0] k, input int l);
    ev_t e;
    e.kind = k;
    e.len  = 32'(l);
    exp_ev.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    ftdi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ftdi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    ftdi_rx = stop;
    repeat (CPB) @(negedge clk);
    ftdi_rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(8'h00, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic send_arg(input logic [7:0] c, input logic [7:0] a);
    send_cmd(c);
    send_byte(a, 1'b1);
  endtask

  task automatic drain_ev(input string tag);
    int   t;
    ev_t  e;
    ev_t  g;
    t = 0;
    while ((got_ev.size() < exp_ev.size() || busy) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_in_time"}, (t < TMO) ? 1 : 0, 1);
    repeat (40) @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_nevents"}, got_ev.size(), exp_ev.size());
    while (exp_ev.size() > 0 && got_ev.size() > 0) begin
      e = exp_ev.pop_front();
      g = got_ev.pop_front();
      check({tag, "_kind"}, g.kind, e.kind);
      check({tag, "_len"}, g.len, e.len);
    end
    exp_ev.delete();
    got_ev.delete();
  endtask

  task automatic drain_tx(input string tag);
    int t;
    t = 0;
    while (got_tx.size() < exp_tx.size() && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_nbytes"}, got_tx.size(), exp_tx.size());
    while (exp_tx.size() > 0 && got_tx.size() > 0)
      check({tag, "_byte"}, got_tx.pop_front(), exp_tx.pop_front());
    check({tag, "_stopbits"}, tx_stop_bad, 0);
    exp_tx.delete();
    got_tx.delete();
  endtask

  // Pulse monitor: turns edges of target_rst/glitch_out into timed events.
  initial begin
    forever begin
      @(negedge clk);
      mon_n++;
      if (target_rst && !prev_r) rise_r = mon_n;
      if (!target_rst && prev_r) begin
        got_ev.push_back({8'h52, 32'(mon_n - rise_r)});
        last_fall = mon_n;
      end
      if (glitch_out && !prev_g) begin
        got_ev.push_back({8'h4C, 32'(mon_n - last_fall)});
        rise_g = mon_n;
      end
      if (!glitch_out && prev_g) begin
        got_ev.push_back({8'h48, 32'(mon_n - rise_g)});
        last_fall = mon_n;
      end
      prev_r = target_rst;
      prev_g = glitch_out;
    end
  end

  // Target UART monitor: decodes 8N1 frames from target_tx.
  initial begin
    forever begin
      @(negedge clk);
      if (target_tx === 1'b0 && rst === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          tx_b[i] = target_tx;
        end
        repeat (CPB) @(negedge clk);
        if (target_tx !== 1'b1) tx_stop_bad++;
        got_tx.push_back(tx_b);
      end
    end
  end

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tx", target_tx, 1);
    check("rst_trst", target_rst, 0);
    check("rst_glitch", glitch_out, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);

    // Defaults: 16-clock reset then one 1-clock pulse straight after.
    send_cmd(8'hFF);
    push_ev("R", RSTC); push_ev("L", 0); push_ev("H", 1);
    send_cmd(8'hFE);
    check("seq1_busy_high", busy, 1);
    drain_ev("seq1");

    // Pass-through to target UART.
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'h55); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h00);
    send_byte(8'h05, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b1);
    drain_tx("pass");
    drain_ev("pass_noev");

    // Width 0x22, one pulse, delay 0x32.
    send_arg(8'h10, 8'h22);
    send_arg(8'h11, 8'h00);
    send_arg(8'h20, 8'h32);
    push_ev("R", RSTC); push_ev("L", 50); push_ev("H", 34);
    send_cmd(8'hFE);
    drain_ev("seq2");

    // Three 3-clock pulses with 3-clock lows.
    send_cmd(8'hFF);
    send_arg(8'h11, 8'h02);
    send_arg(8'h10, 8'h03);
    push_ev("R", RSTC); push_ev("L", 0); push_ev("H", 3);
    push_ev("L", 3); push_ev("H", 3); push_ev("L", 3); push_ev("H", 3);
    send_cmd(8'hFE);
    check("seq3_busy_high", busy, 1);
    drain_ev("seq3");

    // Framing error: a would-be pass-through count is discarded.
    send_byte(8'h03, 1'b0);
    push_ev("R", RSTC); push_ev("L", 0); push_ev("H", 3);
    push_ev("L", 3); push_ev("H", 3); push_ev("L", 3); push_ev("H", 3);
    send_cmd(8'hFE);
    drain_ev("badstop");
    drain_tx("badstop");

    // Abort during a long delay: no glitch ever.
    send_cmd(8'hFF);
    send_arg(8'h21, 8'h04);
    push_ev("R", RSTC);
    send_cmd(8'hFE);
    send_cmd(8'hFF);
    check("abort_busy_low", busy, 0);
    drain_ev("abort");

    // Second start ignored; width write mid-sequence waits for next run.
    send_arg(8'h21, 8'h04);
    push_ev("R", RSTC); push_ev("L", 1024); push_ev("H", 1);
    send_cmd(8'hFE);
    send_arg(8'h10, 8'h05);
    send_cmd(8'hFE);
    check("dbl_busy_high", busy, 1);
    drain_ev("double");

    // Async reset mid-sequence and mid-byte; config must clear.
    send_arg(8'h21, 8'h03);
    push_ev("R", RSTC);
    send_cmd(8'hFE);
    @(negedge clk);
    ftdi_rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", target_tx, 1);
    check("arst_trst", target_rst, 0);
    check("arst_glitch", glitch_out, 0);
    check("arst_busy", busy, 0);
    drain_ev("arst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    ftdi_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    push_ev("R", RSTC); push_ev("L", 0); push_ev("H", 1);
    send_cmd(8'hFE);
    drain_ev("after_rst");
    drain_tx("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glitcher_top.md
GLITCHER_TOP -- requirements
Module: glitcher_top

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz clock, 115200 baud).
REQ-002 SHALL have parameter RST_CYCLES, default 16, meaning target-reset assertion length in clocks.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this single clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ftdi_rx  input  1  host UART receive line, 8N1, idle high.
REQ-006 SHALL have port target_tx  output  1  UART transmit line to target, 8N1, idle high.
REQ-007 SHALL have port target_rst  output  1  target reset, active-high.
REQ-008 SHALL have port glitch_out  output  1  glitch pulse output, active-high.
REQ-009 SHALL have port busy  output  1  high while a glitch sequence runs.

Function
REQ-010 UART receiver SHALL:
- detect the start bit on a falling edge of ftdi_rx;
- sample each bit at mid-bit, LSB first;
- deliver each received byte as a one-cycle strobe;
- discard the byte when the stop bit samples low.
REQ-011 ftdi_rx SHALL pass through a 2-flop synchronizer before use.
REQ-012 Parser states SHALL be IDLE, CMD, ARG, PASS; reset state IDLE.
REQ-013 IDLE: byte 0x00 SHALL go to CMD; byte N (1..255) SHALL go to PASS with remaining = N.
REQ-014 PASS: each byte SHALL be written to the TX FIFO and remaining decremented; remaining reaching 0 SHALL return to IDLE.
REQ-015 CMD, byte 0xFF: all config registers SHALL be set to reset values, any running sequence aborted, and the parser SHALL return to IDLE.
REQ-016 CMD, byte 0x10 (width), 0x11 (pulse count) or 0x20..0x23 (delay byte 0..3, little-endian): SHALL go to ARG.
REQ-017 ARG: the next byte SHALL be written to the selected register, then the parser SHALL return to IDLE.
REQ-018 CMD, byte 0xFE: SHALL start the glitch sequence if not busy (ignored if busy), then the parser SHALL return to IDLE.
REQ-019 CMD, any other byte: SHALL be ignored, return to IDLE.
REQ-020 Registers: width 8-bit, pulse_count 8-bit, delay 32-bit; all reset to 0.
REQ-021 Glitch sequencer states SHALL be IDLE, RESET, DELAY, PULSE_HI, PULSE_LO.
REQ-022 RESET: target_rst SHALL be high for exactly RST_CYCLES clocks.
REQ-023 DELAY: SHALL last exactly delay clocks; 0 SHALL skip directly to PULSE_HI.
REQ-024 PULSE_HI: glitch_out SHALL be high for max(width,1) clocks.
REQ-025 PULSE_LO: glitch_out SHALL be low for max(width,1) clocks; total pulses SHALL be pulse_count+1, with no trailing PULSE_LO after the last pulse.
REQ-026 busy SHALL be high from the 0xFE strobe's next cycle until the sequencer returns to IDLE.
REQ-027 Register writes during a sequence SHALL take effect at the next sequence only; values SHALL be latched at start.
REQ-028 TX FIFO SHALL be 16 bytes deep.
REQ-029 A write while the TX FIFO is full SHALL be dropped.
REQ-030 The UART transmitter SHALL drain the TX FIFO back-to-back in 8N1 at CLKS_PER_BIT, idle high.

Reset
REQ-031 On rst high (async), all outputs SHALL take their reset values: target_tx=1, target_rst=0, glitch_out=0, busy=0.
REQ-032 On rst high, parser and sequencer SHALL go to IDLE, the FIFO SHALL be emptied, and all registers SHALL clear.
REQ-033 Deassertion of rst mid-byte SHALL resume with the receiver waiting for a fresh start bit.

Verification
REQ-034 Send 00 FF, then 00 FE -> one target_rst pulse of 16 clocks, then one glitch_out pulse of 1 clock immediately after, busy deasserts.
REQ-035 Send 00 10 22, 00 11 00, 00 20 32, then 00 FE -> target_rst high 16 clocks, 50 clocks delay, single glitch_out pulse of 34 clocks.
REQ-036 Send 05 FF 55 00 AA 00 -> target_tx emits bytes FF,55,00,AA,00 in order, 8N1, no parser state change.
REQ-037 Set pulse count 02, width 03, then 00 FE -> three 3-clock pulses separated by 3-clock lows.
REQ-038 Send 00 FE, then 00 FF during DELAY -> sequence aborts, glitch_out never rises, busy low.
REQ-039 Send 00 FE, then 00 FE during the sequence -> second start ignored, exactly one sequence.
REQ-040 Send a byte with stop bit low -> byte discarded, parser state unchanged.
